// File: rtl/path_stream_pkg.sv
// Shared types and defaults for the path result streamer and its beat FIFO.
package path_stream_pkg;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_DATA_W-1:0] NO_PATH_WORD = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, HDR, STREAM, NOPATH, DONE} state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
        logic                  err;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry beat FIFO; a push and a pop in the same cycle are both honoured,
// including a push into a full FIFO that is being drained that cycle.
module skid_fifo2
    import path_stream_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [BEAT_W-1:0] push_beat,
    input  logic              pop,
    output logic [BEAT_W-1:0] head,
    output logic [1:0]        count
);
    logic [BEAT_W-1:0] slots [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_beat;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/path_result_streamer.sv
// Streams the shortest-path result (header word N, then N path words) out of the
// output memory onto a valid/ready interface once the engine reports finish.
module path_result_streamer
    import path_stream_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                BASE_ADDR    = 0,
    parameter logic [DATA_W-1:0] NO_PATH_WORD = path_stream_pkg::NO_PATH_WORD
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              n_exist,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_err,
    output logic              busy,
    output logic              done
);
    localparam logic [31:0]       MAX_N = 32'((1 << ADDR_W) - 1 - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic              finish_q;
    logic              trigger;
    logic              in_flight;
    logic              in_flight_last;
    logic              overflow;
    logic [DATA_W-1:0] issue_cnt;
    logic              hdr_over;
    logic              nopath_enter;
    logic              issue;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [BEAT_W-1:0] head_raw;
    beat_t             push_beat;
    beat_t             head_beat;

    assign trigger      = finish && !finish_q;
    assign hdr_over     = 32'(rd_data) > MAX_N;
    assign nopath_enter = ((state == IDLE) && trigger && n_exist) ||
                          ((state == HDR) && (rd_data == '0));
    assign pop          = m_valid && m_ready;
    // The room check credits a same-cycle pop so a steady stream sustains one beat per cycle.
    assign issue        = (state == STREAM) && (issue_cnt != '0) &&
                          ((int'(count) - int'(pop) + int'(in_flight)) < 2);
    assign push         = in_flight || nopath_enter;

    always_comb begin
        push_beat = '0;
        if (nopath_enter) begin
            push_beat.data = NO_PATH_WORD;
            push_beat.last = 1'b1;
            push_beat.err  = 1'b1;
        end else begin
            push_beat.data = rd_data;
            push_beat.last = in_flight_last;
            push_beat.err  = in_flight_last && overflow;
        end
    end

    skid_fifo2 u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head_raw),
        .count     (count)
    );

    assign head_beat = beat_t'(head_raw);
    assign m_valid   = (count != 2'd0);
    assign m_data    = head_beat.data;
    assign m_last    = head_beat.last;
    assign m_err     = head_beat.err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            finish_q       <= 1'b0;
            rd_addr        <= BASE;
            issue_cnt      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            overflow       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            finish_q       <= finish;
            done           <= 1'b0;
            in_flight      <= issue;
            in_flight_last <= issue && (issue_cnt == DATA_W'(1));
            case (state)
                IDLE: begin
                    if (trigger) begin
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        if (n_exist) begin
                            state <= NOPATH;
                        end else begin
                            rd_addr <= BASE;
                            state   <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (rd_data == '0) begin
                        state <= NOPATH;
                    end else begin
                        issue_cnt <= hdr_over ? DATA_W'(MAX_N) : rd_data;
                        overflow  <= hdr_over;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        rd_addr   <= rd_addr + ADDR_W'(1);
                        issue_cnt <= issue_cnt - DATA_W'(1);
                    end
                    if (pop && head_beat.last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                NOPATH: begin
                    if (pop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_path_result_streamer.sv
// Randomized self-checking bench for path_result_streamer against a queue-based
// model of the header/path-word result format.
module tb_path_result_streamer;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAX_N  = DEPTH - 1;

    typedef logic [DATA_W-1:0] word_t;

    logic              clock   = 1'b0;
    logic              reset   = 1'b1;
    logic              finish  = 1'b0;
    logic              n_exist = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    word_t             rd_data;
    logic              m_valid;
    word_t             m_data;
    logic              m_last;
    logic              m_err;
    logic              busy;
    logic              done;

    word_t mem [DEPTH];
    int    checks = 0;
    int    errors = 0;

    word_t exp_data[$];
    logic  exp_last[$];
    logic  exp_err[$];
    word_t got_data[$];
    logic  got_last[$];
    logic  got_err[$];
    int    got_k[$];
    int    addr_log[$];
    int    stall_bad;
    int    done_k;
    int    busy0;
    bit    timed_out;
    logic  pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    assign rd_data = mem[rd_addr];

    always #5 clock = ~clock;

    path_result_streamer #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BASE_ADDR    (0),
        .NO_PATH_WORD (16'hFFFF)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .finish  (finish),
        .n_exist (n_exist),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_err   (m_err),
        .busy    (busy),
        .done    (done)
    );

    // Reference model: the result is either the single no-path beat or words 1..N.
    task automatic build_expected(input logic n_ex);
        int   n;
        logic ov;
        exp_data.delete();
        exp_last.delete();
        exp_err.delete();
        if (n_ex || mem[0] == '0) begin
            exp_data.push_back(16'hFFFF);
            exp_last.push_back(1'b1);
            exp_err.push_back(1'b1);
        end else begin
            n  = int'(mem[0]);
            ov = (n > MAX_N);
            if (ov) n = MAX_N;
            for (int i = 1; i <= n; i++) begin
                exp_data.push_back(mem[i]);
                exp_last.push_back(i == n);
                exp_err.push_back(ov && (i == n));
            end
        end
    endtask

    task automatic start_run(input logic n_ex);
        @(negedge clock);
        n_exist = n_ex;
        finish  = 1'b1;
    endtask

    task automatic stop_finish();
        @(negedge clock);
        finish  = 1'b0;
        n_exist = 1'b0;
    endtask

    // k counts rising edges since the trigger edge; beats are logged at the edge before they transfer.
    task automatic collect(input int mode, input int max_cycles, input int stop_beats);
        logic  prev_stall;
        word_t prev_data;
        logic  prev_last;
        logic  prev_err;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        prev_err   = 1'b0;
        got_data.delete();
        got_last.delete();
        got_err.delete();
        got_k.delete();
        addr_log.delete();
        stall_bad = 0;
        done_k    = -1;
        busy0     = 0;
        timed_out = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clock);
            if (k == 0) busy0 = int'(busy);
            if (addr_log.size() == 0 || addr_log[addr_log.size()-1] != int'(rd_addr))
                addr_log.push_back(int'(rd_addr));
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data ||
                               m_last !== prev_last || m_err !== prev_err))
                stall_bad++;
            if (done === 1'b1) begin
                done_k = k;
                return;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pattern[k % 6];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid === 1'b1 && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_err.push_back(m_err);
                got_k.push_back(k);
                if (stop_beats > 0 && got_data.size() == stop_beats) return;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_err   = m_err;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks += 7;
        if (rd_addr !== '0)  begin errors++; $display("[TB] FAIL reset rd_addr: got %h expected 0", rd_addr); end
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset m_valid: got %b expected 0", m_valid); end
        if (m_data !== '0)   begin errors++; $display("[TB] FAIL reset m_data: got %h expected 0", m_data); end
        if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset m_last: got %b expected 0", m_last); end
        if (m_err !== 1'b0)  begin errors++; $display("[TB] FAIL reset m_err: got %b expected 0", m_err); end
        if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0)   begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic_stream();
        int exp_addr [4] = '{0, 1, 2, 3};
        mem[0] = 16'd3; mem[1] = 16'd5; mem[2] = 16'd9; mem[3] = 16'd12;
        build_expected(1'b0);
        start_run(1'b0);
        collect(0, 50, 0);
        checks += 4;
        if (timed_out) begin errors++; $display("[TB] FAIL basic timeout: got no done expected done"); end
        if (busy0 !== 1) begin errors++; $display("[TB] FAIL basic busy: got %0d expected 1", busy0); end
        if (got_data.size() != exp_data.size()) begin errors++; $display("[TB] FAIL basic count: got %0d expected %0d", got_data.size(), exp_data.size()); end
        if (addr_log.size() != 4) begin errors++; $display("[TB] FAIL basic addr count: got %0d expected 4", addr_log.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks += 2;
            if ({got_data[i], got_last[i], got_err[i]} !== {exp_data[i], exp_last[i], exp_err[i]}) begin
                errors++;
                $display("[TB] FAIL basic beat %0d: got %h/%b/%b expected %h/%b/%b", i, got_data[i], got_last[i], got_err[i], exp_data[i], exp_last[i], exp_err[i]);
            end
            if (got_k[i] != 3 + i) begin errors++; $display("[TB] FAIL basic beat %0d cycle: got %0d expected %0d", i, got_k[i], 3 + i); end
        end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] != exp_addr[i]) begin errors++; $display("[TB] FAIL basic rd_addr %0d: got %0d expected %0d", i, addr_log[i], exp_addr[i]); end
        end
        checks += 1;
        if (done_k != 6) begin errors++; $display("[TB] FAIL basic done cycle: got %0d expected 6", done_k); end
        @(negedge clock);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic done width: got %b expected 0", done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic busy after: got %b expected 0", busy); end
        stop_finish();
    endtask

    task automatic test_no_path(input logic n_ex, input logic [15:0] header, input int exp_k);
        mem[0] = header;
        build_expected(n_ex);
        start_run(n_ex);
        collect(0, 20, 0);
        checks += 5;
        if (timed_out) begin errors++; $display("[TB] FAIL nopath timeout: got no done expected done"); end
        if (got_data.size() != 1) begin errors++; $display("[TB] FAIL nopath count: got %0d expected 1", got_data.size()); end
        if (got_data.size() > 0 && {got_data[0], got_last[0], got_err[0]} !== {exp_data[0], exp_last[0], exp_err[0]}) begin
            errors++;
            $display("[TB] FAIL nopath beat: got %h/%b/%b expected %h/%b/%b", got_data[0], got_last[0], got_err[0], exp_data[0], exp_last[0], exp_err[0]);
        end
        if (got_k.size() > 0 && got_k[0] != exp_k) begin errors++; $display("[TB] FAIL nopath cycle: got %0d expected %0d", got_k[0], exp_k); end
        if (addr_log.size() != 1) begin errors++; $display("[TB] FAIL nopath rd_addr moved: got %0d values expected 1", addr_log.size()); end
        stop_finish();
    endtask

    task automatic test_backpressure(input int n, input int mode, input int iter);
        mem[0] = 16'(n);
        for (int i = 1; i <= n; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        build_expected(1'b0);
        start_run(1'b0);
        collect(mode, 400, 0);
        checks += 3;
        if (timed_out) begin errors++; $display("[TB] FAIL stall %0d timeout: got no done expected done", iter); end
        if (stall_bad != 0) begin errors++; $display("[TB] FAIL stall %0d stability: got %0d changes expected 0", iter, stall_bad); end
        if (got_data.size() != exp_data.size()) begin errors++; $display("[TB] FAIL stall %0d count: got %0d expected %0d", iter, got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_last[i], got_err[i]} !== {exp_data[i], exp_last[i], exp_err[i]}) begin
                errors++;
                $display("[TB] FAIL stall %0d beat %0d: got %h/%b/%b expected %h/%b/%b", iter, i, got_data[i], got_last[i], got_err[i], exp_data[i], exp_last[i], exp_err[i]);
            end
        end
        stop_finish();
    endtask

    task automatic test_held_finish();
        int extra;
        mem[0] = 16'd5;
        for (int i = 1; i <= 5; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        build_expected(1'b0);
        for (int run = 0; run < 2; run++) begin
            start_run(1'b0);
            collect(0, 50, 0);
            checks += 2;
            if (timed_out) begin errors++; $display("[TB] FAIL held run %0d timeout: got no done expected done", run); end
            if (got_data.size() != exp_data.size()) begin errors++; $display("[TB] FAIL held run %0d count: got %0d expected %0d", run, got_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                checks++;
                if ({got_data[i], got_last[i], got_err[i]} !== {exp_data[i], exp_last[i], exp_err[i]}) begin
                    errors++;
                    $display("[TB] FAIL held run %0d beat %0d: got %h/%b/%b expected %h/%b/%b", run, i, got_data[i], got_last[i], got_err[i], exp_data[i], exp_last[i], exp_err[i]);
                end
            end
            extra = 0;
            repeat (10) begin
                @(negedge clock);
                if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) extra++;
            end
            checks++;
            if (extra != 0) begin errors++; $display("[TB] FAIL held run %0d retrigger: got %0d active cycles expected 0", run, extra); end
            stop_finish();
        end
    endtask

    task automatic test_reset_mid_stream();
        mem[0] = 16'd8;
        for (int i = 1; i <= 8; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        start_run(1'b0);
        collect(0, 50, 2);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks += 5;
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort m_valid: got %b expected 0", m_valid); end
        if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
        if (rd_addr !== '0)   begin errors++; $display("[TB] FAIL abort rd_addr: got %h expected 0", rd_addr); end
        if (m_data !== '0)    begin errors++; $display("[TB] FAIL abort m_data: got %h expected 0", m_data); end
        if (m_last !== 1'b0 || m_err !== 1'b0) begin errors++; $display("[TB] FAIL abort flags: got %b%b expected 00", m_last, m_err); end
        finish = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        build_expected(1'b0);
        start_run(1'b0);
        collect(0, 50, 0);
        checks += 3;
        if (timed_out) begin errors++; $display("[TB] FAIL restart timeout: got no done expected done"); end
        if (got_data.size() != exp_data.size()) begin errors++; $display("[TB] FAIL restart count: got %0d expected %0d", got_data.size(), exp_data.size()); end
        if (got_k.size() > 0 && got_k[0] != 3) begin errors++; $display("[TB] FAIL restart first cycle: got %0d expected 3", got_k[0]); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_last[i], got_err[i]} !== {exp_data[i], exp_last[i], exp_err[i]}) begin
                errors++;
                $display("[TB] FAIL restart beat %0d: got %h/%b/%b expected %h/%b/%b", i, got_data[i], got_last[i], got_err[i], exp_data[i], exp_last[i], exp_err[i]);
            end
        end
        stop_finish();
    endtask

    task automatic test_overflow();
        int bad;
        mem[0] = 16'hFFFF;
        for (int i = 1; i < DEPTH; i++) mem[i] = 16'($urandom);
        build_expected(1'b0);
        start_run(1'b0);
        collect(0, MAX_N + 100, 0);
        bad = 0;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            if ({got_data[i], got_last[i], got_err[i]} !== {exp_data[i], exp_last[i], exp_err[i]}) bad++;
        checks += 4;
        if (timed_out) begin errors++; $display("[TB] FAIL overflow timeout: got no done expected done"); end
        if (got_data.size() != MAX_N) begin errors++; $display("[TB] FAIL overflow count: got %0d expected %0d", got_data.size(), MAX_N); end
        if (bad != 0) begin errors++; $display("[TB] FAIL overflow payload: got %0d bad beats expected 0", bad); end
        if (got_data.size() > 0 && {got_last[got_data.size()-1], got_err[got_data.size()-1]} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL overflow last flags: got %b%b expected 11", got_last[got_data.size()-1], got_err[got_data.size()-1]);
        end
        stop_finish();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        test_reset();
        test_basic_stream();
        test_no_path(1'b1, 16'd4, 0);
        test_no_path(1'b0, 16'd0, 1);
        test_backpressure(6, 1, 0);
        for (int it = 1; it <= 4; it++) test_backpressure($urandom_range(1, 12), 2, it);
        test_held_finish();
        test_reset_mid_stream();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
